stochastic_bitstream_generator: RTL and testbench

//  Converts a signed fixed-point value into a signed stochastic bitstream of LENGTH bits.

---
 rtl/stochastic_bitstream_generator.sv | 103 ++++++++++
 tb/tb_stochastic_bitstream_generator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/stochastic_bitstream_generator.sv
// Signed fixed-point to two-channel stochastic bitstream encoder.
// Emits LENGTH bits per value over a valid/ready stream.
module stochastic_bitstream_generator #(
  parameter int RND_WIDTH   = 64,
  parameter int VALUE_WIDTH = 16,
  parameter int FRAC_WIDTH  = 12,
  parameter int LENGTH      = 256
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [RND_WIDTH-1:0]   rnd,
  input  logic [VALUE_WIDTH-1:0] in_value,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_pos,
  output logic                   out_neg,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  localparam logic [FRAC_WIDTH:0] ONE =
    {1'b1, {FRAC_WIDTH{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [FRAC_WIDTH:0]    mag;
  logic                   sign;

  logic [VALUE_WIDTH-1:0] abs_v;
  logic [FRAC_WIDTH:0]    new_mag;
  logic [FRAC_WIDTH:0]    cur_mag;
  logic                   cur_sign;
  logic                   cmp;
  logic                   unused_rnd;

  // Unsigned view of the negated minimum value is exact, so it cannot wrap.
  assign abs_v = in_value[VALUE_WIDTH-1]
               ? (~in_value + 1'b1) : in_value;

  assign new_mag = (abs_v >= VALUE_WIDTH'(ONE))
                 ? ONE : abs_v[FRAC_WIDTH:0];

  assign cur_mag  = (state == IDLE) ? new_mag : mag;
  assign cur_sign = (state == IDLE)
                  ? in_value[VALUE_WIDTH-1] : sign;

  assign cmp = {1'b0, rnd[FRAC_WIDTH-1:0]} < cur_mag;

  assign in_ready   = (state == IDLE);
  assign unused_rnd = ^rnd;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      count     <= '0;
      mag       <= '0;
      sign      <= 1'b0;
      out_valid <= 1'b0;
      out_pos   <= 1'b0;
      out_neg   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= RUN;
            count     <= '0;
            mag       <= new_mag;
            sign      <= cur_sign;
            out_valid <= 1'b1;
            out_pos   <= cmp & ~cur_sign;
            out_neg   <= cmp & cur_sign;
            out_last  <= (LENGTH == 1);
          end
        end
        RUN: begin
          if (out_ready) begin
            if (count == LAST) begin
              state     <= IDLE;
              count     <= '0;
              out_valid <= 1'b0;
              out_pos   <= 1'b0;
              out_neg   <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              count    <= count + 1'b1;
              out_pos  <= cmp & ~cur_sign;
              out_neg  <= cmp & cur_sign;
              out_last <= ((count + 1'b1) == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stochastic_bitstream_generator.sv
// Directed bench for stochastic_bitstream_generator.
// Bench drives rnd itself, so each expected bit comes from its own model.
module tb_stochastic_bitstream_generator;

  localparam int LEN = 256;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [63:0] rnd = '0;
  logic [15:0] in_value = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_pos;
  logic        out_neg;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  stochastic_bitstream_generator #(
    .RND_WIDTH(64), .VALUE_WIDTH(16),
    .FRAC_WIDTH(12), .LENGTH(LEN)
  ) dut (
    .CLK(CLK), .nRST(nRST), .rnd(rnd),
    .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .out_pos(out_pos),
    .out_neg(out_neg), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {pos,neg} from value and the rnd low bits, via integer math.
  function automatic logic [1:0] model(input logic [15:0] v,
                                       input logic [11:0] r);
    int sv;
    int a;
    bit c;
    sv = int'($signed(v));
    a  = (sv < 0) ? -sv : sv;
    if (a > 4096) a = 4096;
    c = int'(r) < a;
    return {c && (sv >= 0), c && (sv < 0)};
  endfunction

  function automatic logic [4:0] obs();
    return {out_valid, out_pos, out_neg, out_last, in_ready};
  endfunction

  task automatic new_rnd();
    rnd = {$urandom(), $urandom()};
  endtask

  // One stream; optional stall, mid-stream value change, hold of in_valid,
  // or reset abort at a given bit index (-1 disables).
  task automatic run_stream(input string tag,
                            input logic [15:0] v,
                            input int stall_at,
                            input int abort_at,
                            input bit hold,
                            input logic [15:0] nextv);
    logic [11:0] r;
    logic [1:0]  e;
    logic [4:0]  exp;
    in_value  = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    new_rnd();
    r = rnd[11:0];
    @(posedge CLK); #1;
    in_valid = hold;
    for (int k = 0; k < LEN; k++) begin
      e   = model(v, r);
      exp = {1'b1, e, (k == LEN - 1), 1'b0};
      chk($sformatf("%s bit%0d", tag, k), 32'(obs()), 32'(exp));
      if (k == abort_at) begin
        nRST = 1'b0;
        #1;
        chk({tag, " rst"}, 32'(obs()), 32'b00001);
        #2;
        nRST = 1'b1;
        in_valid = 1'b0;
        #1;
        chk({tag, " rel"}, 32'(obs()), 32'b00001);
        return;
      end
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          new_rnd();
          @(posedge CLK); #1;
          chk($sformatf("%s stall%0d", tag, s),
              32'(obs()), 32'(exp));
        end
        out_ready = 1'b1;
      end
      if (hold && k == 3) in_value = nextv;
      new_rnd();
      r = rnd[11:0];
      @(posedge CLK); #1;
    end
    chk({tag, " idle"}, 32'(obs()), 32'b00001);
  endtask

  initial begin
    #2;
    chk("reset", 32'(obs()), 32'b00001);
    #10;
    nRST = 1'b1;
    @(posedge CLK); #1;
    chk("post_reset", 32'(obs()), 32'b00001);

    run_stream("half",  16'h0800, -1, -1, 1'b0, '0);
    run_stream("one",   16'h1000, -1, -1, 1'b0, '0);
    run_stream("sat",   16'h7FFF, -1, -1, 1'b0, '0);
    run_stream("zero",  16'h0000, -1, -1, 1'b0, '0);
    run_stream("negq",  16'hFC00, -1, -1, 1'b0, '0);
    run_stream("negmin", 16'h8000, -1, -1, 1'b0, '0);
    run_stream("stall", 16'h0800, 10, -1, 1'b0, '0);
    run_stream("hold",  16'h0400, -1, -1, 1'b1, 16'hF800);
    run_stream("b2b",   16'hF800, -1, -1, 1'b0, '0);
    run_stream("abort", 16'h0C00, -1, 100, 1'b0, '0);
    run_stream("after", 16'hF400, -1, -1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
